// File: rtl/core_ctrl_pkg.sv
// Purpose : shared definitions for the core boot sequencer slice.
//           Holds the sequencer state encoding, default bus widths and the
//           byte-per-word constant used to turn word indices into byte
//           addresses.
// Ports   : none (package).
package core_ctrl_pkg;

    localparam int ADDR_W_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_LOAD    = 3'd2,
        S_RUN     = 3'd3,
        S_READ    = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } boot_state_e;

endpackage

// File: rtl/core_boot_sequencer_cycle_timer.sv
// Purpose : loadable down-counter with a zero flag. The sequencer loads it
//           with (duration - 1) on the edge that enters a timed phase and
//           leaves that phase on the cycle zero_o is high, so the phase
//           lasts exactly 'duration' cycles.
// Ports   : clk_i      - clock, rising edge
//           rst_i      - synchronous active-high reset (count -> 0)
//           load_i     - load load_val_i on the next edge
//           load_val_i - value to load
//           zero_o     - high while the count is zero
module cycle_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/core_boot_sequencer.sv
// Purpose : host-side boot controller for the RISC-V core. On a start pulse
//           it clears the core memories, streams NUM_WORDS instructions from
//           a synchronous program ROM into instruction memory, releases the
//           core reset, lets the core run RUN_CYCLES cycles, reads one word
//           from data memory and compares it with EXPECTED.
// Ports   : clock/reset            - clock, synchronous active-high reset
//           start                  - one-cycle pulse, honoured in IDLE/DONE/ERR
//           rom_addr/rom_data      - ROM word index out, data back one cycle later
//           mem_clr_n/core_reset_n - core memory clear and core reset (active-low)
//           write_ins/addr_ins/dati_ins/ins_memfull - instruction memory write port
//           read_data/addr_data/dato_data           - data memory read port
//           busy/done/pass/error/result             - sequence status
// Handshake: none; start is a plain pulse and every phase is time-based.
module core_boot_sequencer
    import core_ctrl_pkg::*;
#(
    parameter int NUM_WORDS   = 58,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int CLR_CYCLES  = 2,
    parameter int RUN_CYCLES  = 250,
    parameter int READ_CYCLES = 3,
    parameter int RESULT_ADDR = 8,
    parameter int EXPECTED    = 21
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              mem_clr_n,
    output logic              core_reset_n,
    output logic              write_ins,
    output logic [ADDR_W-1:0] addr_ins,
    output logic [DATA_W-1:0] dati_ins,
    input  logic              ins_memfull,
    output logic              read_data,
    output logic [ADDR_W-1:0] addr_data,
    input  logic [DATA_W-1:0] dato_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              error,
    output logic [DATA_W-1:0] result
);

    if (NUM_WORDS < 1 || NUM_WORDS * BYTES_PER_WORD > (1 << ADDR_W)) begin : g_bad_num_words
        $fatal(1, "core_boot_sequencer: NUM_WORDS does not fit the instruction address space");
    end
    if (CLR_CYCLES < 1 || RUN_CYCLES < 1 || READ_CYCLES < 1) begin : g_bad_cycles
        $fatal(1, "core_boot_sequencer: phase durations must be at least one cycle");
    end

    localparam int TMR_W = $clog2(CLR_CYCLES + RUN_CYCLES + READ_CYCLES + 1);

    boot_state_e       state_q, state_d;
    logic              mem_clr_n_q, mem_clr_n_d;
    logic              core_reset_n_q, core_reset_n_d;
    logic              write_ins_q, write_ins_d;
    logic              read_data_q, read_data_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] addr_ins_q, addr_ins_d;
    logic [ADDR_W-1:0] addr_data_q, addr_data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              error_q, error_d;
    // High while rom_addr_q holds a word that still has to be written.
    logic              present_q, present_d;

    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_zero;

    cycle_timer #(.CNT_W(TMR_W)) u_timer (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d        = state_q;
        mem_clr_n_d    = mem_clr_n_q;
        core_reset_n_d = core_reset_n_q;
        write_ins_d    = write_ins_q;
        read_data_d    = read_data_q;
        rom_addr_d     = rom_addr_q;
        addr_ins_d     = addr_ins_q;
        addr_data_d    = addr_data_q;
        result_d       = result_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;
        error_d        = error_q;
        present_d      = present_q;
        tmr_load       = 1'b0;
        tmr_val        = '0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_CLEAR;
                    done_d         = 1'b0;
                    pass_d         = 1'b0;
                    error_d        = 1'b0;
                    busy_d         = 1'b1;
                    core_reset_n_d = 1'b0;
                    mem_clr_n_d    = 1'b0;
                    tmr_load       = 1'b1;
                    tmr_val        = TMR_W'(CLR_CYCLES - 1);
                end
            end
            S_CLEAR: begin
                if (tmr_zero) begin
                    state_d     = S_LOAD;
                    mem_clr_n_d = 1'b1;
                    rom_addr_d  = '0;
                    present_d   = 1'b1;
                end
            end
            S_LOAD: begin
                // Word presented this cycle is written next cycle, when the
                // ROM has its data on rom_data.
                write_ins_d = present_q;
                if (present_q) begin
                    addr_ins_d = rom_addr_q * ADDR_W'(BYTES_PER_WORD);
                    if (rom_addr_q == ADDR_W'(NUM_WORDS - 1)) begin
                        present_d = 1'b0;
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                    end
                end
                if (write_ins_q && ins_memfull) begin
                    state_d     = S_ERR;
                    write_ins_d = 1'b0;
                    present_d   = 1'b0;
                    error_d     = 1'b1;
                    busy_d      = 1'b0;
                end else if (write_ins_q && !present_q) begin
                    // Last word is being written this cycle.
                    state_d        = S_RUN;
                    core_reset_n_d = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_val        = TMR_W'(RUN_CYCLES - 1);
                end
            end
            S_RUN: begin
                if (tmr_zero) begin
                    state_d     = S_READ;
                    read_data_d = 1'b1;
                    addr_data_d = ADDR_W'(RESULT_ADDR);
                    tmr_load    = 1'b1;
                    tmr_val     = TMR_W'(READ_CYCLES - 1);
                end
            end
            S_READ: begin
                if (tmr_zero) begin
                    state_d     = S_CAPTURE;
                    read_data_d = 1'b0;
                end
            end
            S_CAPTURE: begin
                state_d  = S_DONE;
                result_d = dato_data;
                pass_d   = (dato_data == DATA_W'(EXPECTED));
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= S_IDLE;
            mem_clr_n_q    <= 1'b0;
            core_reset_n_q <= 1'b0;
            write_ins_q    <= 1'b0;
            read_data_q    <= 1'b0;
            rom_addr_q     <= '0;
            addr_ins_q     <= '0;
            addr_data_q    <= '0;
            result_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            error_q        <= 1'b0;
            present_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mem_clr_n_q    <= mem_clr_n_d;
            core_reset_n_q <= core_reset_n_d;
            write_ins_q    <= write_ins_d;
            read_data_q    <= read_data_d;
            rom_addr_q     <= rom_addr_d;
            addr_ins_q     <= addr_ins_d;
            addr_data_q    <= addr_data_d;
            result_q       <= result_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            error_q        <= error_d;
            present_q      <= present_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign mem_clr_n    = mem_clr_n_q;
    assign core_reset_n = core_reset_n_q;
    assign write_ins    = write_ins_q;
    assign addr_ins     = addr_ins_q;
    // ROM data arrives in the write cycle itself, so it is passed straight
    // through and held at zero whenever no write is in progress.
    assign dati_ins     = write_ins_q ? rom_data : '0;
    assign read_data    = read_data_q;
    assign addr_data    = addr_data_q;
    assign result       = result_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign error        = error_q;

endmodule

// File: tb/tb_core_boot_sequencer.sv
// Purpose : directed bench for core_boot_sequencer with a ROM model
//           (word idx -> idx + 0x100), a data-memory model returning
//           result_val at byte address 8, an ins_memfull injector and a
//           scoreboard of expected instruction writes.
module tb_core_boot_sequencer;

    localparam int NUM     = 58;
    localparam int LAT     = 316;
    localparam int BUDGET  = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        mem_clr_n;
    logic        core_reset_n;
    logic        write_ins;
    logic [7:0]  addr_ins;
    logic [31:0] dati_ins;
    logic        ins_memfull;
    logic        read_data;
    logic [7:0]  addr_data;
    logic [31:0] dato_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic        error;
    logic [31:0] result;

    logic [31:0] result_val;
    logic        memfull_en;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc, wr_count, first_wr, last_wr, clr_low, crn_first, rd_cnt, lat;

    logic [31:0] exp_q[$];
    logic [7:0]  exp_a_q[$];

    core_boot_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .mem_clr_n    (mem_clr_n),
        .core_reset_n (core_reset_n),
        .write_ins    (write_ins),
        .addr_ins     (addr_ins),
        .dati_ins     (dati_ins),
        .ins_memfull  (ins_memfull),
        .read_data    (read_data),
        .addr_data    (addr_data),
        .dato_data    (dato_data),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .error        (error),
        .result       (result)
    );

    // clock / models
    always #5 clock = ~clock;

    always @(posedge clock) rom_data <= 32'h100 + 32'(rom_addr);

    always @(posedge clock) begin
        if (read_data) dato_data <= (addr_data == 8'd8) ? result_val : 32'hDEAD_BEEF;
    end

    // Memory reports full during the 10th write of a sequence.
    assign ins_memfull = memfull_en & write_ins & (wr_count >= 10);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock, then sample #1 after the edge and run the monitor/scoreboard.
    task automatic tick();
        logic [31:0] e_d;
        logic [7:0]  e_a;
        @(posedge clock);
        #1;
        n_cyc++;
        if (write_ins) begin
            wr_count++;
            if (first_wr == 0) first_wr = n_cyc;
            last_wr = n_cyc;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_d = exp_q.pop_front();
                e_a = exp_a_q.pop_front();
                check("dati_ins", dati_ins, e_d);
                check("addr_ins", 32'(addr_ins), 32'(e_a));
                check("core_rst_in_load", 32'(core_reset_n), 32'd0);
            end
        end
        if (!mem_clr_n && busy) clr_low++;
        if (core_reset_n && crn_first == 0) crn_first = n_cyc;
        if (read_data) begin
            rd_cnt++;
            check("addr_data", 32'(addr_data), 32'd8);
        end
    endtask

    task automatic check_reset_vals();
        check("rst_mem_clr_n", 32'(mem_clr_n), 32'd0);
        check("rst_core_reset_n", 32'(core_reset_n), 32'd0);
        check("rst_write_ins", 32'(write_ins), 32'd0);
        check("rst_read_data", 32'(read_data), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_addr_ins", 32'(addr_ins), 32'd0);
        check("rst_dati_ins", dati_ins, 32'd0);
        check("rst_addr_data", 32'(addr_data), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_error", 32'(error), 32'd0);
    endtask

    // Pushes the expected load, pulses start, then runs until done, error,
    // or wr_count reaches stop_wr (when nonzero). pulse_at injects a second
    // start pulse at that cycle (0 = none). lat_o is the cycle count at exit.
    task automatic run_seq(input int pulse_at, input int stop_wr, output int lat_o);
        n_cyc = 0; wr_count = 0; first_wr = 0; last_wr = 0;
        clr_low = 0; crn_first = 0; rd_cnt = 0;
        exp_q.delete();
        exp_a_q.delete();
        for (int i = 0; i < NUM; i++) begin
            exp_q.push_back(32'h100 + 32'(i));
            exp_a_q.push_back(8'(i * 4));
        end
        lat_o = 0;
        start = 1'b1;
        for (int n = 1; n <= BUDGET; n++) begin
            tick();
            if (n == 1) begin
                start = 1'b0;
                check("start_done_clr", 32'(done), 32'd0);
                check("start_busy", 32'(busy), 32'd1);
                check("start_mem_clr_n", 32'(mem_clr_n), 32'd0);
                check("start_core_rst", 32'(core_reset_n), 32'd0);
            end
            if (n == pulse_at) start = 1'b1;
            if (n == pulse_at + 1) start = 1'b0;
            if (done || error || (stop_wr != 0 && wr_count == stop_wr)) begin
                lat_o = n;
                break;
            end
        end
        n_tests++;
        assert (lat_o != 0) else begin
            n_fail++;
            $error("FAIL seq_timeout: observed no completion in %0d cycles expected completion", BUDGET);
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        memfull_en = 1'b0;
        result_val = 32'd21;
        n_cyc = 0; wr_count = 0; first_wr = 0; last_wr = 0;
        clr_low = 0; crn_first = 0; rd_cnt = 0; lat = 0;

        // Reset state
        repeat (3) tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Full load/run/readback, result matches
        run_seq(0, 0, lat);
        check("lat_pass", 32'(lat), 32'(LAT));
        check("done", 32'(done), 32'd1);
        check("pass", 32'(pass), 32'd1);
        check("result", result, 32'd21);
        check("busy_done", 32'(busy), 32'd0);
        check("error_clear", 32'(error), 32'd0);
        check("wr_count", 32'(wr_count), 32'(NUM));
        check("wr_contig", 32'(last_wr - first_wr + 1), 32'(NUM));
        check("first_wr_cyc", 32'(first_wr), 32'd4);
        check("core_rel_cyc", 32'(crn_first), 32'd62);
        check("clr_cycles", 32'(clr_low), 32'd2);
        check("read_cycles", 32'(rd_cnt), 32'd3);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("core_runs", 32'(core_reset_n), 32'd1);

        // Restart from DONE, wrong result, stray start during RUN
        result_val = 32'd20;
        run_seq(100, 0, lat);
        check("lat_fail", 32'(lat), 32'(LAT));
        check("done2", 32'(done), 32'd1);
        check("pass2", 32'(pass), 32'd0);
        check("result2", result, 32'd20);
        check("wr_count2", 32'(wr_count), 32'(NUM));

        // Instruction memory full on the 10th write
        memfull_en = 1'b1;
        run_seq(0, 0, lat);
        check("mf_error", 32'(error), 32'd1);
        check("mf_busy", 32'(busy), 32'd0);
        check("mf_done", 32'(done), 32'd0);
        check("mf_wr_count", 32'(wr_count), 32'd10);
        repeat (5) tick();
        check("mf_no_more_wr", 32'(wr_count), 32'd10);
        check("mf_core_never_rel", 32'(crn_first), 32'd0);
        check("mf_error_sticky", 32'(error), 32'd1);
        memfull_en = 1'b0;

        // Reset during LOAD at word 30, then a clean reload
        result_val = 32'd21;
        run_seq(0, 30, lat);
        check("rl_stop_cyc", 32'(lat), 32'd33);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0;
        repeat (3) tick();
        check("rl_no_wr_after_rst", 32'(wr_count), 32'd30);
        run_seq(0, 0, lat);
        check("rl_lat", 32'(lat), 32'(LAT));
        check("rl_pass", 32'(pass), 32'd1);
        check("rl_wr_count", 32'(wr_count), 32'(NUM));
        check("rl_first_wr", 32'(first_wr), 32'd4);
        check("rl_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
